clk_period_meter: RTL and testbench

- Receive-side counterpart of clk_divider: measures the period and high time of an asynchronous, divided or external clock/pulse input (e.g. a divided timing clock or ACP/ARP strobe) in IN_CLK cycles.
- Results go out on a valid/ready handshake to the control/status logic.
- Timeout, glitch-reject and overrun flags support link supervision in the radar simulator.

---
 rtl/clk_period_meter.sv | 147 ++++++++++++++
 tb/tb_clk_period_meter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period and high-time meter for an asynchronous clock/pulse input
//
// Ports:
//   IN_CLK       in   system clock, all logic on its rising edge
//   IN_RSTN      in   asynchronous active-low reset
//   EN           in   measurement enable (sync to IN_CLK); low clears state and sticky flags
//   MEAS_CLK     in   asynchronous signal under measurement
//   OUT_READY    in   consumer accepts the current result
//   OUT_VALID    out  result available, held until accepted
//   PERIOD       out  IN_CLK cycles between consecutive qualified rising edges
//   HIGH_TIME    out  IN_CLK cycles from the rising edge to the last falling edge of that period
//   TIMEOUT_FLAG out  sticky: no qualified rising edge within TIMEOUT cycles
//   OVERRUN      out  sticky: an unaccepted result was overwritten

module clk_period_meter #(
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = 1000000,
    parameter int MIN_PERIOD = 4
) (
    input  logic                 IN_CLK,
    input  logic                 IN_RSTN,
    input  logic                 EN,
    input  logic                 MEAS_CLK,
    input  logic                 OUT_READY,
    output logic                 OUT_VALID,
    output logic [CNT_WIDTH-1:0] PERIOD,
    output logic [CNT_WIDTH-1:0] HIGH_TIME,
    output logic                 TIMEOUT_FLAG,
    output logic                 OVERRUN
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] MIN_P     = CNT_WIDTH'(MIN_PERIOD);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] hi_lat;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 s1, s2, s3;
    logic                 rise_det;
    logic                 fall_det;
    logic                 qual_rise;

    // Synchronizer and history flop run regardless of EN so that edges are
    // never fabricated from stale samples when measurement is re-enabled.
    always_ff @(posedge IN_CLK or negedge IN_RSTN) begin
        if (!IN_RSTN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= MEAS_CLK;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Rise and fall share the same synchronizer path, so their latencies
    // cancel when differences are taken.
    assign rise_det = s2 & ~s3;
    assign fall_det = ~s2 & s3;

    // In ARM any edge starts a measurement; in MEASURE edges closer than
    // MIN_PERIOD to the previous qualified edge are treated as glitches.
    assign qual_rise = rise_det && ((state == ARM) || ((state == MEASURE) && (cnt >= MIN_P)));

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge IN_CLK or negedge IN_RSTN) begin
        if (!IN_RSTN) begin
            state        <= IDLE;
            cnt          <= CNT_ZERO;
            hi_lat       <= CNT_ZERO;
            OUT_VALID    <= 1'b0;
            PERIOD       <= CNT_ZERO;
            HIGH_TIME    <= CNT_ZERO;
            TIMEOUT_FLAG <= 1'b0;
            OVERRUN      <= 1'b0;
        end else if (!EN) begin
            // Disable discards any pending result and clears sticky flags.
            state        <= IDLE;
            cnt          <= CNT_ZERO;
            hi_lat       <= CNT_ZERO;
            OUT_VALID    <= 1'b0;
            TIMEOUT_FLAG <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            // Acceptance drops OUT_VALID unless a new result loads below.
            if (OUT_VALID && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt   <= CNT_ZERO;
                    state <= ARM;
                end

                ARM: begin
                    cnt <= cnt_inc;
                    if (qual_rise) begin
                        state  <= MEASURE;
                        cnt    <= CNT_ONE;
                        hi_lat <= CNT_ZERO;
                    end
                end

                MEASURE: begin
                    cnt <= cnt_inc;
                    if (fall_det) begin
                        hi_lat <= cnt;
                    end
                    // A qualified edge on the timeout cycle still counts as
                    // a valid period; timeout only fires without one.
                    if (qual_rise) begin
                        PERIOD    <= cnt;
                        HIGH_TIME <= hi_lat;
                        OUT_VALID <= 1'b1;
                        if (OUT_VALID && !OUT_READY) begin
                            OVERRUN <= 1'b1;
                        end
                        cnt    <= CNT_ONE;
                        hi_lat <= CNT_ZERO;
                    end else if (cnt == TIMEOUT_C) begin
                        TIMEOUT_FLAG <= 1'b1;
                        state        <= ARM;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter
module tb_clk_period_meter;

    localparam int CW = 16;
    localparam int TO = 100;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic          meas;
    logic          ready;
    logic          valid;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          tflag;
    logic          ovr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int ev_t[$];
    bit ev_v[$];
    int got_p[$];
    int got_h[$];
    int exp_p[$];
    int exp_h[$];
    bit exp_to;

    typedef struct {
        int p;
        int h;
        int n;
        bit rdy;
        bit glitch;
        int exp_cnt;
        int exp_per;
        int exp_hi;
        bit exp_valid;
        bit exp_ovr;
        bit exp_to;
    } vec_t;

    vec_t tbl[8];

    clk_period_meter #(
        .CNT_WIDTH (CW),
        .TIMEOUT   (TO),
        .MIN_PERIOD(MP)
    ) dut (
        .IN_CLK      (clk),
        .IN_RSTN     (rstn),
        .EN          (en),
        .MEAS_CLK    (meas),
        .OUT_READY   (ready),
        .OUT_VALID   (valid),
        .PERIOD      (period),
        .HIGH_TIME   (high_time),
        .TIMEOUT_FLAG(tflag),
        .OVERRUN     (ovr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every accepted result, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1 && ready === 1'b1) begin
            got_p.push_back(int'(period));
            got_h.push_back(int'(high_time));
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_meas(input bit v);
        if (v != meas) begin
            ev_t.push_back(cyc);
            ev_v.push_back(v);
        end
        meas = v;
    endtask

    task automatic start_run();
        en = 1'b0;
        set_meas(1'b0);
        tick(4);
        ev_t.delete();
        ev_v.delete();
        got_p.delete();
        got_h.delete();
        en = 1'b1;
        tick(3);
    endtask

    task automatic send_period(input int p, input int h, input bit glitch);
        if (!glitch) begin
            set_meas(1'b1); tick(h);
            set_meas(1'b0); tick(p - h);
        end else begin
            set_meas(1'b1); tick(1);
            set_meas(1'b0); tick(1);
            set_meas(1'b1); tick(1);
            set_meas(1'b0); tick(p - 3);
        end
    endtask

    // Reference: walk the recorded edge times of MEAS_CLK. Periods are
    // differences of rise times, high time is the last fall minus the rise.
    task automatic run_model();
        bit measuring = 1'b0;
        int r  = 0;
        int hl = 0;
        exp_p.delete();
        exp_h.delete();
        exp_to = 1'b0;
        for (int i = 0; i < ev_t.size(); i++) begin
            int t = ev_t[i];
            if (measuring && (t - r > TO)) begin
                measuring = 1'b0;
                exp_to    = 1'b1;
            end
            if (ev_v[i]) begin
                if (!measuring) begin
                    measuring = 1'b1;
                    r  = t;
                    hl = 0;
                end else if (t - r >= MP) begin
                    exp_p.push_back(t - r);
                    exp_h.push_back(hl);
                    r  = t;
                    hl = 0;
                end
            end else if (measuring) begin
                hl = t - r;
            end
        end
    endtask

    initial begin
        int c;
        int n0;

        //         p    h   n  rdy gl  cnt per  hi  vld ovr to
        tbl[0] = '{30,  15, 3, 1,  0,  3,  30,  15, 0,  0,  0};
        tbl[1] = '{30,  15, 3, 0,  0,  0,  30,  15, 1,  1,  0};
        tbl[2] = '{7,   3,  4, 1,  0,  4,  7,   3,  0,  0,  0};
        tbl[3] = '{4,   1,  3, 1,  0,  3,  4,   1,  0,  0,  0};
        tbl[4] = '{100, 50, 2, 1,  0,  2,  100, 50, 0,  0,  0};
        tbl[5] = '{101, 1,  2, 1,  0,  0,  0,   0,  0,  0,  1};
        tbl[6] = '{3,   1,  4, 1,  0,  2,  6,   4,  0,  0,  0};
        tbl[7] = '{30,  0,  2, 1,  1,  2,  30,  3,  0,  0,  0};

        rstn  = 1'b0;
        en    = 1'b0;
        meas  = 1'b0;
        ready = 1'b0;
        tick(2);
        check("rst_valid", valid, 0);
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_timeout", tflag, 0);
        check("rst_overrun", ovr, 0);
        rstn = 1'b1;
        tick(2);

        // Table-driven periodic waveforms
        for (int i = 0; i < 8; i++) begin
            start_run();
            ready = tbl[i].rdy;
            for (int k = 0; k < tbl[i].n; k++) send_period(tbl[i].p, tbl[i].h, tbl[i].glitch);
            set_meas(1'b1);
            tick(8);
            check($sformatf("v%0d_count", i), got_p.size(), tbl[i].exp_cnt);
            for (int k = 0; k < got_p.size(); k++) begin
                check($sformatf("v%0d_period%0d", i, k), got_p[k], tbl[i].exp_per);
                check($sformatf("v%0d_high%0d", i, k), got_h[k], tbl[i].exp_hi);
            end
            if (!tbl[i].rdy) begin
                check($sformatf("v%0d_held_period", i), period, tbl[i].exp_per);
                check($sformatf("v%0d_held_high", i), high_time, tbl[i].exp_hi);
            end
            check($sformatf("v%0d_valid", i), valid, tbl[i].exp_valid);
            check($sformatf("v%0d_overrun", i), ovr, tbl[i].exp_ovr);
            check($sformatf("v%0d_timeout", i), tflag, tbl[i].exp_to);
            if (!tbl[i].rdy) begin
                en = 1'b0;
                tick(1);
                check($sformatf("v%0d_dis_overrun", i), ovr, 0);
                check($sformatf("v%0d_dis_valid", i), valid, 0);
                en = 1'b1;
            end
            ready = 1'b0;
        end

        // Acceptance in the same cycle a new result loads
        start_run();
        ready = 1'b0;
        send_period(30, 15, 1'b0);
        set_meas(1'b1);
        tick(5);
        check("acc_first_valid", valid, 1);
        check("acc_first_period", period, 30);
        set_meas(1'b0);
        tick(15);
        set_meas(1'b1);
        tick(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("acc_valid", valid, 1);
        check("acc_period", period, 20);
        check("acc_high", high_time, 5);
        check("acc_overrun", ovr, 0);
        ready = 1'b1;
        tick(1);
        check("acc_cleared", valid, 0);
        ready = 1'b0;

        // Timeout exactly TO cycles after the last qualified rise
        start_run();
        ready = 1'b1;
        send_period(30, 15, 1'b0);
        c = cyc;
        set_meas(1'b1);
        tick(15);
        set_meas(1'b0);
        tick(c + 102 - cyc);
        check("to_before", tflag, 0);
        tick(1);
        check("to_at", tflag, 1);
        check("to_results", got_p.size(), 1);
        n0 = got_p.size();
        send_period(30, 15, 1'b0);
        check("to_rearm_noresult", got_p.size(), n0);
        set_meas(1'b1);
        tick(8);
        check("to_next_result", got_p.size(), n0 + 1);
        if (got_p.size() == n0 + 1) check("to_next_period", got_p[n0], 30);
        check("to_sticky", tflag, 1);

        // Asynchronous reset in the middle of a period
        start_run();
        ready = 1'b0;
        send_period(30, 15, 1'b0);
        send_period(30, 15, 1'b0);
        set_meas(1'b1);
        tick(15);
        set_meas(1'b0);
        tick(5);
        check("prerst_valid", valid, 1);
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", valid, 0);
        check("arst_period", period, 0);
        check("arst_high", high_time, 0);
        check("arst_overrun", ovr, 0);
        check("arst_timeout", tflag, 0);
        tick(2);
        #3 rstn = 1'b1;
        ready = 1'b1;
        got_p.delete();
        got_h.delete();
        tick(5);
        send_period(30, 15, 1'b0);
        check("post_rst_one_rise", got_p.size(), 0);
        set_meas(1'b1);
        tick(8);
        check("post_rst_count", got_p.size(), 1);
        if (got_p.size() == 1) begin
            check("post_rst_period", got_p[0], 30);
            check("post_rst_high", got_h[0], 15);
        end

        // Randomized edge sequences against the event-time model
        start_run();
        ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int sel;
            int p;
            int h;
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      p = int'($urandom_range(4, 90));
            else if (sel < 8) p = int'($urandom_range(2, 3));
            else              p = int'($urandom_range(95, 130));
            h = int'($urandom_range(1, p - 1));
            send_period(p, h, 1'b0);
        end
        set_meas(1'b1);
        tick(8);
        run_model();
        check("rnd_count", got_p.size(), exp_p.size());
        for (int k = 0; k < got_p.size() && k < exp_p.size(); k++) begin
            check($sformatf("rnd_period%0d", k), got_p[k], exp_p[k]);
            check($sformatf("rnd_high%0d", k), got_h[k], exp_h[k]);
        end
        check("rnd_timeout", tflag, exp_to);
        check("rnd_overrun", ovr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
